blackjack_round_fsm: RTL and testbench

Round sequencer for one player versus the dealer. It requests cards from the deck with a req/valid handshake and routes each card to the player or dealer hand controller. It runs the deal, player and dealer turns under 5-card Charlie rules, then posts the round result. It sits between the deck block, the two hand controllers and the button/display logic.

---
 rtl/blackjack_round_fsm.sv | 193 +++++++++++++++++++
 tb/tb_blackjack_round_fsm.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_round_fsm.sv
// rtl/blackjack_round_fsm.sv - round sequencer: deal, player turn, dealer turn, settle under 5-card Charlie rules
module blackjack_round_fsm #(
    parameter int CARD_W       = 4,
    parameter int SUM_W        = 5,
    parameter int BUST_LIMIT   = 21,
    parameter int DEALER_STAND = 17,
    parameter int MAX_CARDS    = 5
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_hit,
    input  logic              i_stand,
    output logic              o_cardReq,
    input  logic              i_cardValid,
    input  logic [CARD_W-1:0] i_card,
    output logic              o_handReset,
    output logic              o_addPlayerCard,
    output logic              o_addDealerCard,
    output logic [CARD_W-1:0] o_newCard,
    input  logic [SUM_W-1:0]  i_playerSum,
    input  logic [SUM_W-1:0]  i_dealerSum,
    input  logic [2:0]        i_playerCount,
    input  logic [2:0]        i_dealerCount,
    output logic              o_hideDealerHole,
    output logic [3:0]        o_state,
    output logic [1:0]        o_result,
    output logic              o_roundDone
);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        CLEAR       = 4'd1,
        DEAL_P0     = 4'd2,
        DEAL_D0     = 4'd3,
        DEAL_P1     = 4'd4,
        DEAL_D1     = 4'd5,
        PLAYER_TURN = 4'd6,
        PLAYER_DRAW = 4'd7,
        DEALER_TURN = 4'd8,
        DEALER_DRAW = 4'd9,
        SETTLE      = 4'd10,
        DONE        = 4'd11
    } state_t;

    localparam logic [SUM_W:0]   BUST_L  = (SUM_W+1)'(BUST_LIMIT);
    localparam logic [SUM_W-1:0] STAND_L = SUM_W'(DEALER_STAND);
    localparam logic [2:0]       MAX_L   = 3'(MAX_CARDS);

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic                card_req_q, card_req_d;
    logic                hand_reset_q, hand_reset_d;
    logic                add_p_q, add_p_d;
    logic                add_d_q, add_d_d;
    logic [CARD_W-1:0]   new_card_q, new_card_d;
    logic                hide_q, hide_d;
    logic [1:0]          result_q, result_d;
    logic                p_bust_q, p_bust_d;
    logic                d_bust_q, d_bust_d;

    logic                to_player;
    logic                is_draw_d;
    logic [SUM_W-1:0]    sum_sel;
    logic                bust_now;

    assign to_player = (state_q == DEAL_P0) || (state_q == DEAL_P1) || (state_q == PLAYER_DRAW);
    assign sum_sel   = to_player ? i_playerSum : i_dealerSum;
    // Widened by one bit so a 5-bit hand sum wrapping past 31 still reads as bust.
    assign bust_now  = ({1'b0, sum_sel} + {{(SUM_W+1-CARD_W){1'b0}}, i_card}) > BUST_L;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        hand_reset_d = 1'b0;
        add_p_d      = 1'b0;
        add_d_d      = 1'b0;
        new_card_d   = new_card_q;
        hide_d       = hide_q;
        result_d     = result_q;
        p_bust_d     = p_bust_q;
        d_bust_d     = d_bust_q;
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d      = CLEAR;
                    hand_reset_d = 1'b1;
                    result_d     = 2'b00;
                    hide_d       = 1'b0;
                    p_bust_d     = 1'b0;
                    d_bust_d     = 1'b0;
                end
            end
            CLEAR: begin
                state_d = DEAL_P0;
                phase_d = 2'd0;
            end
            DEAL_P0, DEAL_D0, DEAL_P1, DEAL_D1, PLAYER_DRAW, DEALER_DRAW: begin
                case (phase_q)
                    2'd0: begin
                        if (i_cardValid) begin
                            phase_d    = 2'd1;
                            new_card_d = i_card;
                            add_p_d    = to_player;
                            add_d_d    = !to_player;
                            if (to_player) p_bust_d = p_bust_q | bust_now;
                            else           d_bust_d = d_bust_q | bust_now;
                            if (state_q == DEAL_D1) hide_d = 1'b1;
                        end
                    end
                    2'd1: phase_d = 2'd2;
                    default: begin
                        // Hand sums have settled; decide where the round goes next.
                        phase_d = 2'd0;
                        case (state_q)
                            DEAL_P0: state_d = DEAL_D0;
                            DEAL_D0: state_d = DEAL_P1;
                            DEAL_P1: state_d = DEAL_D1;
                            DEAL_D1: state_d = PLAYER_TURN;
                            PLAYER_DRAW: begin
                                if (p_bust_q || i_playerCount == MAX_L) state_d = SETTLE;
                                else                                    state_d = PLAYER_TURN;
                            end
                            default: state_d = DEALER_TURN;
                        endcase
                    end
                endcase
            end
            PLAYER_TURN: begin
                if (p_bust_q)                                 state_d = SETTLE;
                else if (i_playerSum == BUST_L[SUM_W-1:0] || i_stand) state_d = DEALER_TURN;
                else if (i_hit)                               state_d = PLAYER_DRAW;
            end
            DEALER_TURN: begin
                hide_d = 1'b0;
                if (!d_bust_q && i_dealerSum < STAND_L && i_dealerCount < MAX_L) state_d = DEALER_DRAW;
                else                                                             state_d = SETTLE;
            end
            SETTLE: begin
                state_d = DONE;
                if (p_bust_q)                        result_d = 2'b10;
                else if (i_playerCount == MAX_L)     result_d = 2'b01;
                else if (d_bust_q)                   result_d = 2'b01;
                else if (i_playerSum > i_dealerSum)  result_d = 2'b01;
                else if (i_playerSum < i_dealerSum)  result_d = 2'b10;
                else                                 result_d = 2'b11;
            end
            default: state_d = IDLE;
        endcase
        is_draw_d  = (state_d == DEAL_P0) || (state_d == DEAL_D0) || (state_d == DEAL_P1) ||
                     (state_d == DEAL_D1) || (state_d == PLAYER_DRAW) || (state_d == DEALER_DRAW);
        card_req_d = is_draw_d && (phase_d == 2'd0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            phase_q      <= 2'd0;
            card_req_q   <= 1'b0;
            hand_reset_q <= 1'b0;
            add_p_q      <= 1'b0;
            add_d_q      <= 1'b0;
            new_card_q   <= '0;
            hide_q       <= 1'b0;
            result_q     <= 2'b00;
            p_bust_q     <= 1'b0;
            d_bust_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            card_req_q   <= card_req_d;
            hand_reset_q <= hand_reset_d;
            add_p_q      <= add_p_d;
            add_d_q      <= add_d_d;
            new_card_q   <= new_card_d;
            hide_q       <= hide_d;
            result_q     <= result_d;
            p_bust_q     <= p_bust_d;
            d_bust_q     <= d_bust_d;
        end
    end

    assign o_cardReq        = card_req_q;
    assign o_handReset      = hand_reset_q;
    assign o_addPlayerCard  = add_p_q;
    assign o_addDealerCard  = add_d_q;
    assign o_newCard        = new_card_q;
    assign o_hideDealerHole = hide_q;
    assign o_state          = state_q;
    assign o_result         = result_q;
    assign o_roundDone      = (state_q == DONE);

endmodule

// File: tb/tb_blackjack_round_fsm.sv
// tb/tb_blackjack_round_fsm.sv - scoreboard bench for blackjack_round_fsm with deck and hand models
module tb_blackjack_round_fsm;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_start = 1'b0, i_hit = 1'b0, i_stand = 1'b0;
    logic       o_cardReq;
    logic       i_cardValid = 1'b0;
    logic [3:0] i_card = 4'd0;
    logic       o_handReset, o_addPlayerCard, o_addDealerCard;
    logic [3:0] o_newCard;
    logic [4:0] i_playerSum = 5'd0, i_dealerSum = 5'd0;
    logic [2:0] i_playerCount = 3'd0, i_dealerCount = 3'd0;
    logic       o_hideDealerHole;
    logic [3:0] o_state;
    logic [1:0] o_result;
    logic       o_roundDone;

    blackjack_round_fsm dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_hit(i_hit), .i_stand(i_stand),
        .o_cardReq(o_cardReq), .i_cardValid(i_cardValid), .i_card(i_card),
        .o_handReset(o_handReset), .o_addPlayerCard(o_addPlayerCard), .o_addDealerCard(o_addDealerCard),
        .o_newCard(o_newCard), .i_playerSum(i_playerSum), .i_dealerSum(i_dealerSum),
        .i_playerCount(i_playerCount), .i_dealerCount(i_dealerCount),
        .o_hideDealerHole(o_hideDealerHole), .o_state(o_state), .o_result(o_result),
        .o_roundDone(o_roundDone)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       pl;
        logic [3:0] card;
    } stb_t;

    stb_t       sq[$];
    logic [1:0] rq[$];
    logic [3:0] deck[$];
    int         n_cmp = 0, n_bad = 0;
    int         d0_stall = 0, req_d0_cnt = 0;
    logic       prev_strobe = 1'b0, done_prev = 1'b0;
    logic [3:0] cv[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Deck: answers a pending request on the falling edge, optionally stalling during DEAL_D0.
    always @(negedge i_clk) begin
        if (i_reset_n && o_cardReq) begin
            if (o_state == 4'd3) req_d0_cnt++;
            if (o_state == 4'd3 && d0_stall > 0) begin
                d0_stall--;
                i_cardValid = 1'b0;
            end else if (deck.size() > 0) begin
                i_cardValid = 1'b1;
                i_card = deck.pop_front();
            end else begin
                i_cardValid = 1'b0;
            end
        end else begin
            i_cardValid = 1'b0;
        end
    end

    // Hand controllers: plain accumulators with 5-bit wrap.
    always @(negedge i_clk) begin
        if (!i_reset_n || o_handReset) begin
            i_playerSum = 5'd0; i_dealerSum = 5'd0;
            i_playerCount = 3'd0; i_dealerCount = 3'd0;
        end else begin
            if (o_addPlayerCard) begin
                i_playerSum = i_playerSum + {1'b0, o_newCard};
                i_playerCount = i_playerCount + 3'd1;
            end
            if (o_addDealerCard) begin
                i_dealerSum = i_dealerSum + {1'b0, o_newCard};
                i_dealerCount = i_dealerCount + 3'd1;
            end
        end
    end

    // Monitor: pops the scoreboard on every add strobe and on entry to DONE.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_addPlayerCard || o_addDealerCard) begin
                chk("strobe_overlap", {31'd0, o_addPlayerCard & o_addDealerCard}, 32'd0);
                chk("strobe_back_to_back", {31'd0, prev_strobe}, 32'd0);
                if (sq.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
                else begin
                    stb_t e;
                    e = sq.pop_front();
                    chk("strobe_target_card", {27'd0, o_addPlayerCard, o_newCard}, {27'd0, e.pl, e.card});
                end
            end
            if (o_roundDone && !done_prev) begin
                if (rq.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
                else chk("round_result", {30'd0, o_result}, {30'd0, rq.pop_front()});
            end
        end
        prev_strobe = o_addPlayerCard | o_addDealerCard;
        done_prev   = o_roundDone;
    end

    task automatic pulse_start();
        @(posedge i_clk); #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
    endtask

    task automatic run_round(input int ncards, input logic [3:0] c[8], input logic [7:0] tgt,
                             input int hits, input logic [1:0] res, input int lat, input int mode);
        int cyc;
        int hits_left;
        bit first;
        for (int i = 0; i < ncards; i++) begin
            deck.push_back(c[i]);
            sq.push_back('{pl: tgt[i], card: c[i]});
        end
        rq.push_back(res);
        pulse_start();
        cyc = 0;
        while (o_state != 4'd6 && !o_roundDone && cyc < 400) begin
            @(posedge i_clk); #1 cyc++;
        end
        if (lat >= 0) chk("deal_latency", cyc, lat);
        hits_left = hits;
        first = 1'b1;
        cyc = 0;
        while (!o_roundDone && cyc < 2000) begin
            if (o_state == 4'd6) begin
                if (first) chk("hole_hidden_in_player_turn", {31'd0, o_hideDealerHole}, 32'd1);
                if (mode == 1 && first) begin
                    pulse_start();
                    chk("start_ignored_in_player_turn", {28'd0, o_state}, 32'd6);
                    i_hit = 1'b1; i_stand = 1'b1;
                    @(posedge i_clk); #1 i_hit = 1'b0; i_stand = 1'b0;
                    chk("hit_and_stand_goes_dealer", {28'd0, o_state}, 32'd8);
                end else if (hits_left > 0) begin
                    hits_left--;
                    i_hit = 1'b1;
                    @(posedge i_clk); #1 i_hit = 1'b0;
                end else begin
                    i_stand = 1'b1;
                    @(posedge i_clk); #1 i_stand = 1'b0;
                end
                first = 1'b0;
            end else begin
                @(posedge i_clk); #1;
            end
            cyc++;
        end
        if (cyc >= 2000) chk("round_timeout", 32'd1, 32'd0);
        @(negedge i_clk); #1;
        chk("leftover_expected", sq.size() + rq.size(), 32'd0);
        if (o_roundDone) chk("hole_revealed_or_bust", 32'd1, 32'd1 & ~(o_hideDealerHole & ~(res == 2'b10 || res == 2'b01)));
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_state", {28'd0, o_state}, 32'd0);
        chk("reset_cardReq", {31'd0, o_cardReq}, 32'd0);
        chk("reset_outputs", {25'd0, o_handReset, o_addPlayerCard, o_addDealerCard, o_hideDealerHole,
                              o_result, o_roundDone}, 32'd0);
        i_reset_n = 1'b1;

        cv = '{4'd10, 4'd9, 4'd7, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0};
        run_round(4, cv, 8'b0000_0101, 0, 2'b10, 13, 0);

        req_d0_cnt = 0;
        d0_stall = 7;
        run_round(4, cv, 8'b0000_0101, 0, 2'b10, -1, 0);
        chk("d0_req_high_cycles", req_d0_cnt, 32'd8);

        cv = '{4'd10, 4'd5, 4'd6, 4'd6, 4'd11, 4'd0, 4'd0, 4'd0};
        run_round(5, cv, 8'b0001_0101, 1, 2'b10, 13, 0);

        cv = '{4'd2, 4'd10, 4'd2, 4'd6, 4'd3, 4'd4, 4'd2, 4'd0};
        run_round(7, cv, 8'b0111_0101, 3, 2'b01, 13, 0);

        cv = '{4'd10, 4'd10, 4'd9, 4'd6, 4'd10, 4'd0, 4'd0, 4'd0};
        run_round(5, cv, 8'b0000_0101, 0, 2'b01, 13, 0);

        cv = '{4'd10, 4'd10, 4'd8, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0};
        run_round(4, cv, 8'b0000_0101, 0, 2'b11, 13, 0);

        cv = '{4'd10, 4'd10, 4'd7, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0};
        run_round(4, cv, 8'b0000_0101, 0, 2'b10, 13, 1);

        // Abandon a round while DEAL_P1 waits on an empty deck.
        deck.push_back(4'd10); deck.push_back(4'd9);
        sq.push_back('{pl: 1'b1, card: 4'd10});
        sq.push_back('{pl: 1'b0, card: 4'd9});
        pulse_start();
        cyc = 0;
        while (o_state != 4'd4 && cyc < 200) begin
            @(posedge i_clk); #1 cyc++;
        end
        chk("reached_deal_p1", {28'd0, o_state}, 32'd4);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); #2 i_reset_n = 1'b0;
        #1;
        chk("reset_drops_cardReq", {31'd0, o_cardReq}, 32'd0);
        chk("reset_mid_round_state", {28'd0, o_state}, 32'd0);
        chk("reset_mid_round_result", {30'd0, o_result}, 32'd0);
        chk("reset_mid_round_leftover", sq.size(), 32'd0);
        deck.delete();
        @(posedge i_clk); #1 i_reset_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 chk("idle_after_reset", {27'd0, o_state, o_roundDone}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
